// File: rtl/sccb_master.sv
// sccb_master: byte-level SCCB master that turns one (ID, register, value)
// request into a 3-phase SCCB write on SIOC/SIOD.
// Optional macro SCCB_READ_EN adds rw/siod_i/rd_data and a 2-phase-write +
// 2-phase-read register read sequence.
module sccb_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dev_id,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
`ifdef SCCB_READ_EN
  input  logic       rw,
  input  logic       siod_i,
  output logic [7:0] rd_data,
`endif
  output logic       ready,
  output logic       done,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
);

  localparam int unsigned QW = 16;
  localparam int unsigned SW = 5;
  localparam int unsigned FW = 27;
  localparam logic [QW-1:0] Q_LAST  = QW'(CLK_DIV - 1);
  localparam logic [SW-1:0] LAST_WR = SW'(26);
  localparam logic [SW-1:0] LAST_RD = SW'(17);

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    qph, qph_n;
  logic [SW-1:0] slot, slot_n, last_slot;
  logic [FW-1:0] frame, frame_n;
  logic          rd_q, rd_n;
  logic          seg_q, seg_n;
  logic          tick;
  logic          ready_d, done_d, sioc_d, siod_d, oe_d;
`ifdef SCCB_READ_EN
  logic [7:0]    rd_sh, rd_sh_n;
`endif

  // End of the current quarter-period
  assign tick      = (qcnt == Q_LAST);
  // Read transactions carry two 18-slot segments instead of one 27-slot frame
  assign last_slot = rd_q ? LAST_RD : LAST_WR;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      qph     <= '0;
      slot    <= '0;
      frame   <= '0;
      rd_q    <= 1'b0;
      seg_q   <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      sioc    <= 1'b1;
      siod_o  <= 1'b1;
      siod_oe <= 1'b1;
`ifdef SCCB_READ_EN
      rd_sh   <= '0;
      rd_data <= '0;
`endif
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      qph     <= qph_n;
      slot    <= slot_n;
      frame   <= frame_n;
      rd_q    <= rd_n;
      seg_q   <= seg_n;
      ready   <= ready_d;
      done    <= done_d;
      sioc    <= sioc_d;
      siod_o  <= siod_d;
      siod_oe <= oe_d;
`ifdef SCCB_READ_EN
      rd_sh   <= rd_sh_n;
      if (done_d) rd_data <= rd_sh_n;
`endif
    end
  end

  // Next state: quarter/phase/slot sequencing and frame capture
  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    qph_n   = qph;
    slot_n  = slot;
    frame_n = frame;
    rd_n    = rd_q;
    seg_n   = seg_q;
`ifdef SCCB_READ_EN
    rd_sh_n = rd_sh;
`endif
    if (state != IDLE) qcnt_n = tick ? '0 : qcnt + QW'(1);
    case (state)
      IDLE: begin
        if (start && ready) begin
          state_n = START;
          qcnt_n  = '0;
          qph_n   = '0;
          slot_n  = '0;
          seg_n   = 1'b0;
          // Don't-care slots are stored as 1 so a released line reads idle-high
          frame_n = {dev_id & 8'hFE, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
`ifdef SCCB_READ_EN
          rd_n    = rw;
`else
          rd_n    = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (qph == 2'd2) begin
            state_n = BITS;
            qph_n   = '0;
            slot_n  = '0;
          end else begin
            qph_n = qph + 2'd1;
          end
        end
      end
      BITS: begin
        if (tick) begin
`ifdef SCCB_READ_EN
          if (seg_q && (qph == 2'd2) && (slot >= SW'(9)) && (slot <= SW'(16)))
            rd_sh_n = {rd_sh[6:0], siod_i};
`endif
          if (qph == 2'd3) begin
            qph_n = '0;
            if (slot == last_slot) begin
              state_n = STOP;
              slot_n  = '0;
            end else begin
              slot_n = slot + SW'(1);
            end
          end else begin
            qph_n = qph + 2'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qph == 2'd2) begin
            qph_n = '0;
            if (rd_q && !seg_q) begin
              // Second segment: ID|1, ack slot, 8 read slots, NA slot
              state_n = START;
              seg_n   = 1'b1;
              frame_n = {frame[26:20], 1'b1, 1'b1, 8'hFF, 1'b1, 9'h1FF};
            end else begin
              state_n = IDLE;
            end
          end else begin
            qph_n = qph + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the next state so the pins register in step with it
  always_comb begin
    sioc_d  = 1'b1;
    siod_d  = 1'b1;
    oe_d    = 1'b1;
    ready_d = (state_n == IDLE);
    done_d  = (state_n == STOP) && (qph_n == 2'd2) && (qcnt_n == Q_LAST) &&
              !(rd_n && !seg_n);
    case (state_n)
      START: begin
        siod_d = 1'b0;
        sioc_d = (qph_n != 2'd2);
      end
      BITS: begin
        sioc_d = qph_n[1];
        siod_d = frame_n[SW'(26) - slot_n];
        if (seg_n)
          oe_d = !((slot_n >= SW'(8)) && (slot_n <= SW'(16)));
        else
          oe_d = !((slot_n == SW'(8)) || (slot_n == SW'(17)) || (slot_n == SW'(26)));
      end
      STOP: begin
        sioc_d = (qph_n != 2'd0);
        siod_d = (qph_n == 2'd2);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: directed bench for sccb_master with a byte scoreboard
// decoded from SIOD at SIOC rising edges.
module tb_sccb_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int WR_LEN = 114 * CLK_DIV;
  localparam int RD_LEN = 156 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dev_id = 8'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       rw = 1'b0;
  logic       siod_i = 1'b1;
  logic [7:0] rd_data;
  logic       ready, done, sioc, siod_o, siod_oe;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       mon_wr = 1'b0;
  int         starts = 0;
  int         stops = 0;
  int         rise_i = -1;
  logic [7:0] mon_sh = 8'h00;
  logic       p_sioc = 1'b1;
  logic       p_bus = 1'b1;

  sccb_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dev_id   (dev_id),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
`ifdef SCCB_READ_EN
    .rw       (rw),
    .siod_i   (siod_i),
    .rd_data  (rd_data),
`endif
    .ready    (ready),
    .done     (done),
    .sioc     (sioc),
    .siod_o   (siod_o),
    .siod_oe  (siod_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Issue one request; returns #1 after the acceptance edge (cycle 1)
  task automatic issue(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                       input logic r);
    @(negedge clk);
    dev_id = id; reg_addr = a; reg_data = d; rw = r; start = 1'b1;
    if (!r) begin
      exp_q.push_back(id & 8'hFE);
      exp_q.push_back(a);
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    dev_id = ~id; reg_addr = ~a; reg_data = ~d; rw = 1'b0;
    chk("accept_ready_low", ready, 1'b0);
  endtask

  // Cycle index (acceptance cycle = 0) at which done is seen, -1 on timeout
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int n = 2; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Bus monitor: START/STOP detection and byte decode at SIOC rising edges
  initial forever begin
    logic bus;
    @(negedge clk);
    bus = siod_oe ? siod_o : 1'b1;
    if (rst) begin
      rise_i = -1;
    end else begin
      if (p_sioc && sioc && (bus !== p_bus)) begin
        if (!bus) begin
          starts++;
          rise_i = 0;
        end else begin
          stops++;
        end
      end
      if (!p_sioc && sioc && mon_wr && (rise_i >= 0) && (rise_i < 27)) begin
        if ((rise_i == 8) || (rise_i == 17) || (rise_i == 26)) begin
          chk("dc_slot_released", siod_oe, 1'b0);
        end else begin
          mon_sh = {mon_sh[6:0], bus};
          if ((rise_i == 7) || (rise_i == 16) || (rise_i == 25)) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $error("FAIL byte_unexpected observed=0x%0h expected=none", mon_sh);
            end else begin
              chk("byte", mon_sh, exp_q.pop_front());
            end
          end
        end
        rise_i++;
      end
    end
    p_sioc = sioc;
    p_bus = bus;
  end

`ifdef SCCB_READ_EN
  logic       slv_en = 1'b0;
  int         fall_n = 0;
  int         rr_n = 0;
  logic       s_prev = 1'b1;
  logic [7:0] slv_val = 8'h76;

  // Slave model: drives read data after SIOC falls, checks the NA slot
  initial forever begin
    @(negedge clk);
    if (slv_en) begin
      if (s_prev && !sioc) fall_n++;
      if (!s_prev && sioc) begin
        rr_n++;
        if (rr_n == 37) begin
          chk("rd_na_siod", siod_o, 1'b1);
          chk("rd_na_oe", siod_oe, 1'b1);
        end
      end
      siod_i = ((fall_n >= 29) && (fall_n <= 36)) ? slv_val[36 - fall_n] : 1'b1;
    end
    s_prev = sioc;
  end
`endif

  initial begin
    int n;
    int gap;
    int pulses;

    // Reset with start asserted
    rst = 1'b1; start = 1'b1; dev_id = 8'h43; reg_addr = 8'h12; reg_data = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sioc", sioc, 1'b1);
    chk("rst_siod", siod_o, 1'b1);
    chk("rst_oe", siod_oe, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_sioc", sioc, 1'b1);

    // Single write
    mon_wr = 1'b1; starts = 0; stops = 0;
    issue(8'h43, 8'h12, 8'h80, 1'b0);
    wait_done(WR_LEN + 50, n);
    chk("wr_len", n, WR_LEN);
    @(posedge clk);
    #1;
    chk("wr_ready_after", ready, 1'b1);
    chk("wr_done_one_cycle", done, 1'b0);
    chk("wr_start_cond", starts, 1);
    chk("wr_stop_cond", stops, 1);
    chk("wr_bytes_left", exp_q.size(), 0);

    // Back-to-back with start held high
    starts = 0; stops = 0;
    @(negedge clk);
    dev_id = 8'h60; reg_addr = 8'h3A; reg_data = 8'h5C; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h60);
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'h5C);
    end
    @(posedge clk);
    #1;
    chk("b2b_ready_low", ready, 1'b0);
    wait_done(WR_LEN + 50, n);
    chk("b2b_first_len", n, WR_LEN);
    gap = -1;
    for (int i = 1; i <= WR_LEN + 50; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        gap = i;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_gap", gap, WR_LEN + 1);
    pulses = 0;
    for (int i = 0; i < WR_LEN + 50; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    chk("b2b_extra_done", pulses, 0);
    chk("b2b_start_cond", starts, 2);
    chk("b2b_stop_cond", stops, 2);
    chk("b2b_bytes_left", exp_q.size(), 0);

    // Reset at cycle 200 of a transaction
    issue(8'h42, 8'h55, 8'hAA, 1'b0);
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_sioc", sioc, 1'b1);
    chk("mid_rst_siod", siod_o, 1'b1);
    chk("mid_rst_oe", siod_oe, 1'b1);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    chk("mid_rst_idle_ready", ready, 1'b1);

    starts = 0; stops = 0;
    issue(8'h30, 8'h0F, 8'hF0, 1'b0);
    wait_done(WR_LEN + 50, n);
    chk("after_rst_len", n, WR_LEN);
    chk("after_rst_start_cond", starts, 1);
    chk("after_rst_bytes_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("after_rst_ready", ready, 1'b1);

`ifdef SCCB_READ_EN
    // Register read
    mon_wr = 1'b0; fall_n = 0; rr_n = 0; slv_en = 1'b1;
    issue(8'h42, 8'h0A, 8'h00, 1'b1);
    wait_done(RD_LEN + 50, n);
    chk("rd_len", n, RD_LEN);
    chk("rd_data", rd_data, 8'h76);
    chk("rd_rises", rr_n, 38);
    slv_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rd_ready_after", ready, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
